// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC/IR, request/ack IMEM port, next-PC select, IRQ synchronizer.
// Latency: 2+ cycles/instruction (FETCH until ACK, then one EXEC); stalls in FETCH while ACK is low.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
    parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  PCSEL,
    input  logic [31:0] JT,
    input  logic        IRQ_IN,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] INSTR,
    output logic [5:0]  OPCODE,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        pc_31,
    output logic        IRQ,
    output logic        HOLD
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic        r_pending;

    logic        w_imem_req;
    logic        w_hold;
    logic        w_capture;
    logic        w_pc_load;
    logic        w_irq_clr;
    logic        w_irq_set;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_sum;
    logic [31:0] w_next_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_hold      = 1'b1;
        w_capture   = 1'b0;
        w_pc_load   = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (IMEM_ACK) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_hold      = 1'b0;
                w_pc_load   = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bits 30:0 wrap on their own; bit 31 (supervisor) never changes through sequential/branch flow.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_sum   = w_pc_plus4 + w_br_off;

    always_comb begin
        w_next_pc = ILLOP_VECTOR;
        case (PCSEL)
            3'd0:    w_next_pc = (w_pc_plus4 & 32'h7FFF_FFFC) | (r_pc & 32'h8000_0000);
            3'd1:    w_next_pc = (w_br_sum & 32'h7FFF_FFFC) | (r_pc & 32'h8000_0000);
            3'd2:    w_next_pc = ({r_pc[31] & JT[31], JT[30:0]}) & 32'hFFFF_FFFC;
            3'd4:    w_next_pc = XADR_VECTOR;
            default: w_next_pc = ILLOP_VECTOR;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= 32'd0;
        end else begin
            if (w_capture) begin
                r_instr <= IMEM_DATA;
            end
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // s3 delays s2 so that only a rising synchronized level sets the pending flag.
    assign w_irq_clr = (r_state == ST_EXEC) && (PCSEL == 3'd4);
    assign w_irq_set = r_s2 & ~r_s3;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_s1      <= IRQ_IN;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pending <= (r_pending & ~w_irq_clr) | w_irq_set;
        end
    end

    assign IMEM_ADDR = r_pc;
    assign IMEM_REQ  = w_imem_req;
    assign HOLD      = w_hold;
    assign INSTR     = r_instr;
    assign OPCODE    = r_instr[31:26];
    assign PC        = r_pc;
    assign PC_PLUS4  = w_pc_plus4;
    assign pc_31     = r_pc[31];
    assign IRQ       = r_pending;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized instruction stream,
// scoreboard of expected EXEC-cycle outputs checked by an independent monitor.
module tb_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [2:0]  PCSEL;
    logic [31:0] JT;
    logic        IRQ_IN;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic [31:0] INSTR;
    logic [5:0]  OPCODE;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        pc_31;
    logic        IRQ;
    logic        HOLD;

    fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .PCSEL(PCSEL), .JT(JT), .IRQ_IN(IRQ_IN),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK),
        .IMEM_DATA(IMEM_DATA), .INSTR(INSTR), .OPCODE(OPCODE), .PC(PC),
        .PC_PLUS4(PC_PLUS4), .pc_31(pc_31), .IRQ(IRQ), .HOLD(HOLD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_irq;
    logic        prev_sample;
    int          ecnt;
    int          set_edges[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Architectural next-PC rule, computed with plain integer arithmetic on the 31-bit field.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                               input logic [2:0] sel, input logic [31:0] jt);
        longint m;
        longint lo;
        longint off;
        m = 64'h8000_0000;
        case (sel)
            3'd0: begin
                lo = (longint'(pc[30:0]) + 4) % m;
                return {pc[31], 31'(lo)} & 32'hFFFF_FFFC;
            end
            3'd1: begin
                off = longint'($signed(instr[15:0])) * 4;
                lo  = ((longint'(pc[30:0]) + 4 + off) % m + m) % m;
                return {pc[31], 31'(lo)} & 32'hFFFF_FFFC;
            end
            3'd2:    return {pc[31] & jt[31], jt[30:0]} & 32'hFFFF_FFFC;
            3'd4:    return 32'h8000_0008;
            default: return 32'h8000_0004;
        endcase
    endfunction

    // One clock edge; the IRQ model schedules a set two edges after a rising sample.
    task automatic tick(input bit clr);
        logic smp;
        logic set_now;
        smp = IRQ_IN;
        @(posedge CLK);
        #1;
        ecnt++;
        if (smp && !prev_sample) set_edges.push_back(ecnt + 2);
        prev_sample = smp;
        set_now = 1'b0;
        if (set_edges.size() > 0 && set_edges[0] == ecnt) begin
            set_now = 1'b1;
            void'(set_edges.pop_front());
        end
        exp_irq = set_now | (exp_irq & ~clr);
        check("irq", {31'd0, IRQ}, {31'd0, exp_irq});
    endtask

    // One full instruction: d wait cycles, ACK cycle, EXEC cycle. irq_edge: fetch-relative
    // edge index at which IRQ_IN is sampled high (-1 none, -2 held high throughout).
    task automatic do_instr(input int d, input logic [31:0] data, input logic [2:0] sel,
                            input logic [31:0] jt, input int irq_edge, input bit rnd);
        int          k;
        logic [31:0] nxt;
        k = 0;
        for (int i = 0; i < d; i++) begin
            IMEM_ACK  = 1'b0;
            IMEM_DATA = $urandom;
            IRQ_IN    = rnd ? ($urandom_range(0, 5) == 0) : ((irq_edge == -2) || (k == irq_edge));
            check("wait_req", {31'd0, IMEM_REQ}, 32'd1);
            check("wait_hold", {31'd0, HOLD}, 32'd1);
            check("wait_addr", IMEM_ADDR, exp_pc);
            check("wait_instr", INSTR, exp_instr);
            tick(1'b0);
            k++;
        end
        IMEM_ACK  = 1'b1;
        IMEM_DATA = data;
        IRQ_IN    = rnd ? ($urandom_range(0, 5) == 0) : ((irq_edge == -2) || (k == irq_edge));
        check("ack_req", {31'd0, IMEM_REQ}, 32'd1);
        check("ack_addr", IMEM_ADDR, exp_pc);
        exp_instr = data;
        exp_q.push_back('{pc: exp_pc, instr: data});
        tick(1'b0);
        k++;
        IMEM_ACK  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        IMEM_DATA = $urandom;
        PCSEL     = sel;
        JT        = jt;
        IRQ_IN    = rnd ? ($urandom_range(0, 5) == 0) : ((irq_edge == -2) || (k == irq_edge));
        nxt = model_next(exp_pc, exp_instr, sel, jt);
        tick(sel == 3'd4);
        exp_pc   = nxt;
        IMEM_ACK = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && !HOLD) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL exec_unexpected: HOLD low with no fetched instruction at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("exec_pc", PC, e.pc);
                check("exec_instr", INSTR, e.instr);
                check("exec_opcode", {26'd0, OPCODE}, {26'd0, e.instr[31:26]});
                check("exec_pc_plus4", PC_PLUS4, e.pc + 32'd4);
                check("exec_pc31", {31'd0, pc_31}, {31'd0, e.pc[31]});
                check("exec_req", {31'd0, IMEM_REQ}, 32'd0);
            end
        end
    end

    initial begin
        RESET = 1'b1; PCSEL = 3'd0; JT = 32'd0; IRQ_IN = 1'b0;
        IMEM_ACK = 1'b0; IMEM_DATA = 32'd0;
        exp_pc = 32'h8000_0000; exp_instr = 32'd0; exp_irq = 1'b0;
        prev_sample = 1'b0; ecnt = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", PC, 32'h8000_0000);
        check("rst_addr", IMEM_ADDR, 32'h8000_0000);
        check("rst_hold", {31'd0, HOLD}, 32'd1);
        check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
        check("rst_instr", INSTR, 32'd0);
        check("rst_opcode", {26'd0, OPCODE}, 32'd0);
        check("rst_pc_plus4", PC_PLUS4, 32'h8000_0004);
        check("rst_pc31", {31'd0, pc_31}, 32'd1);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        RESET = 1'b0;
        tick(1'b0);
        check("first_req", {31'd0, IMEM_REQ}, 32'd1);
        check("first_addr", IMEM_ADDR, 32'h8000_0000);

        do_instr(0, 32'hC000_0000, 3'd0, 32'd0, -1, 1'b0);
        check("seq_pc", PC, 32'h8000_0004);
        do_instr(3, 32'h1234_5678, 3'd0, 32'd0, -1, 1'b0);
        check("delay_pc", PC, 32'h8000_0008);

        do_instr(0, 32'h0000_0000, 3'd2, 32'h8000_0010, -1, 1'b0);
        do_instr(1, 32'h7000_FFFE, 3'd1, 32'd0, -1, 1'b0);
        check("branch_back", PC, 32'h8000_000C);
        do_instr(0, 32'h0000_0000, 3'd2, 32'h8000_0010, -1, 1'b0);
        do_instr(2, 32'h7000_0003, 3'd1, 32'd0, -1, 1'b0);
        check("branch_fwd", PC, 32'h8000_0020);

        do_instr(0, 32'h0000_0000, 3'd2, 32'h8000_0100, -1, 1'b0);
        do_instr(0, 32'h6C00_0000, 3'd2, 32'h0000_0043, -1, 1'b0);
        check("jump_user", PC, 32'h0000_0040);
        do_instr(1, 32'h6C00_0000, 3'd2, 32'h8000_1000, -1, 1'b0);
        check("jump_nosup", PC, 32'h0000_1000);
        check("jump_pc31", {31'd0, pc_31}, 32'd0);
        do_instr(0, 32'h0000_0000, 3'd2, 32'h0000_0000, -1, 1'b0);
        do_instr(0, 32'h0000_0000, 3'd2, 32'h0000_0000, -1, 1'b0);
        check("wrap_jump", PC, 32'h0000_0000);

        do_instr(4, 32'h0400_0000, 3'd0, 32'd0, 0, 1'b0);
        check("irq_set", {31'd0, IRQ}, 32'd1);
        do_instr(1, 32'h0400_0000, 3'd0, 32'd0, -1, 1'b0);
        check("irq_held", {31'd0, IRQ}, 32'd1);
        do_instr(0, 32'h0400_0000, 3'd4, 32'd0, -1, 1'b0);
        check("xadr_pc", PC, 32'h8000_0008);
        check("irq_cleared", {31'd0, IRQ}, 32'd0);
        do_instr(4, 32'h0400_0000, 3'd0, 32'd0, 0, 1'b0);
        do_instr(2, 32'h0400_0000, 3'd4, 32'd0, 1, 1'b0);
        check("irq_set_wins", {31'd0, IRQ}, 32'd1);
        do_instr(3, 32'h0400_0000, 3'd4, 32'd0, -2, 1'b0);
        do_instr(2, 32'h0400_0000, 3'd4, 32'd0, -2, 1'b0);
        check("irq_level_once", {31'd0, IRQ}, 32'd0);
        IRQ_IN = 1'b0;
        do_instr(0, 32'hFFFF_FFFF, 3'd6, 32'd0, -1, 1'b0);
        check("illop_pc", PC, 32'h8000_0004);

        for (int n = 0; n < 250; n++) begin
            do_instr($urandom_range(0, 3), $urandom, 3'($urandom_range(0, 7)), $urandom, -1, 1'b1);
        end
        IRQ_IN = 1'b0;

        do_instr(0, 32'hDEAD_BEEF, 3'd2, 32'h0000_0100, -1, 1'b0);
        do_instr(0, 32'hDEAD_BEEF, 3'd0, 32'd0, -1, 1'b0);
        check("sb_drained", exp_q.size(), 32'd0);
        IMEM_ACK  = 1'b1;
        IMEM_DATA = 32'hFFFF_FFFF;
        #2;
        RESET = 1'b1;
        #1;
        check("arst_instr", INSTR, 32'd0);
        check("arst_pc", PC, 32'h8000_0000);
        check("arst_hold", {31'd0, HOLD}, 32'd1);
        check("arst_req", {31'd0, IMEM_REQ}, 32'd0);
        check("arst_irq", {31'd0, IRQ}, 32'd0);
        @(posedge CLK);
        #1;
        check("arst_nocapture", INSTR, 32'd0);
        RESET    = 1'b0;
        IMEM_ACK = 1'b0;
        @(posedge CLK);
        #1;
        check("rearm_req", {31'd0, IMEM_REQ}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
